cfg_chain_loader: RTL and testbench

- Upstream feeder of the switchbox/tile configuration scan chain.
- Accepts configuration words from the bitstream source over a valid/ready handshake and serializes them MSB-first onto the chain, one bit per clock, asserting config_en while shifting.
- Counts exactly CHAIN_LEN bits, then stops, so routing state lands in the correct chain positions.
- Flags completion and handshake errors to the global config controller.

---
 rtl/cfg_chain_loader.sv | 189 ++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
//   Feeds the switchbox/tile configuration scan chain. Configuration words
//   arrive over a valid/ready handshake and are shifted MSB-first onto the
//   chain, one bit per clock, with config_en high while shifting. Exactly
//   CHAIN_LEN bits are shifted per load; a short final word sends only its
//   low bits.
//
//   Optional feature macro: CFG_CHAIN_LOADER_CRC_EN
//     When defined, a CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) runs
//     over the shifted stream. After the last chain bit one extra word is
//     accepted and its low 16 bits are compared with the CRC; a mismatch sets
//     error. config_data_in is then sampled on every config_en cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      begin a load (IDLE/DONE only) / cancel back to IDLE
//   word_data/valid   incoming configuration word and its valid
//   word_ready        loader accepts a word this cycle
//   config_en         chain shift enable
//   config_data_out   serial bit into the chain head
//   config_data_in    serial bit from the chain tail (CRC build only)
//   busy, done, error status to the global config controller
module cfg_chain_loader #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 256,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              config_en,
   output logic              config_data_out,
   input  logic              config_data_in,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int WC_W = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
`ifdef CFG_CHAIN_LOADER_CRC_EN
      S_CRC,
`endif
      S_DONE
   } state_t;

   state_t            state_reg,     state_next;
   logic [CNT_W-1:0]  bits_left_reg, bits_left_next;
   logic [WC_W-1:0]   word_left_reg, word_left_next;
   logic [WORD_W-1:0] shift_reg,     shift_next;
   logic              error_reg,     error_next;
   logic [31:0]       word_n;

   // Bits taken from the word being accepted: min(WORD_W, bits_left).
   assign word_n = (32'(bits_left_reg) >= 32'(WORD_W)) ? 32'(WORD_W)
                                                       : 32'(bits_left_reg);

`ifdef CFG_CHAIN_LOADER_CRC_EN
   logic [15:0] crc_reg, crc_next;
   logic        crc_fb;
   logic        tail_reg;
   logic        unused_tail;

   assign crc_fb      = crc_reg[15] ^ shift_reg[WORD_W-1];
   assign unused_tail = tail_reg;
`else
   logic        unused_tail;

   assign unused_tail = config_data_in;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         bits_left_reg <= '0;
         word_left_reg <= '0;
         shift_reg     <= '0;
         error_reg     <= 1'b0;
`ifdef CFG_CHAIN_LOADER_CRC_EN
         crc_reg       <= 16'hFFFF;
         tail_reg      <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         bits_left_reg <= bits_left_next;
         word_left_reg <= word_left_next;
         shift_reg     <= shift_next;
         error_reg     <= error_next;
`ifdef CFG_CHAIN_LOADER_CRC_EN
         crc_reg       <= crc_next;
         if (config_en) begin
            tail_reg <= config_data_in;
         end
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      bits_left_next = bits_left_reg;
      word_left_next = word_left_reg;
      shift_next     = shift_reg;
      error_next     = error_reg;
`ifdef CFG_CHAIN_LOADER_CRC_EN
      crc_next       = crc_reg;
`endif
      case (state_reg)
         S_IDLE, S_DONE: begin
            if (start) begin
               bits_left_next = CNT_W'(CHAIN_LEN);
               error_next     = 1'b0;
`ifdef CFG_CHAIN_LOADER_CRC_EN
               crc_next       = 16'hFFFF;
`endif
               state_next     = S_LOAD;
            end
         end
         S_LOAD: begin
            if (word_valid) begin
               // MSB-align the used bits; a short word's upper bits fall off.
               shift_next     = word_data << (32'(WORD_W) - word_n);
               word_left_next = WC_W'(word_n);
               state_next     = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shift_next     = {shift_reg[WORD_W-2:0], 1'b0};
            bits_left_next = bits_left_reg - CNT_W'(1);
            word_left_next = word_left_reg - WC_W'(1);
`ifdef CFG_CHAIN_LOADER_CRC_EN
            crc_next       = {crc_reg[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
            if (word_left_reg == WC_W'(1)) begin
               if (bits_left_reg == CNT_W'(1)) begin
`ifdef CFG_CHAIN_LOADER_CRC_EN
                  state_next = S_CRC;
`else
                  state_next = S_DONE;
`endif
               end else begin
                  state_next = S_LOAD;
               end
            end
         end
`ifdef CFG_CHAIN_LOADER_CRC_EN
         S_CRC: begin
            if (word_valid) begin
               if (16'(word_data) != crc_reg) begin
                  error_next = 1'b1;
               end
               state_next = S_DONE;
            end
         end
`endif
         default: state_next = S_IDLE;
      endcase

      // A start that arrives mid-load is a controller protocol error.
      if (start && busy) begin
         error_next = 1'b1;
      end
      // Abort overrides everything, including a simultaneous start.
      if (abort) begin
         state_next = S_IDLE;
         error_next = error_reg;
      end
   end

`ifdef CFG_CHAIN_LOADER_CRC_EN
   assign word_ready = (state_reg == S_LOAD) || (state_reg == S_CRC);
   assign busy       = (state_reg == S_LOAD) || (state_reg == S_SHIFT) || (state_reg == S_CRC);
`else
   assign word_ready = (state_reg == S_LOAD);
   assign busy       = (state_reg == S_LOAD) || (state_reg == S_SHIFT);
`endif
   assign config_en       = (state_reg == S_SHIFT);
   assign config_data_out = config_en & shift_reg[WORD_W-1];
   assign done            = (state_reg == S_DONE);
   assign error           = error_reg;

endmodule

// File: tb/tb_cfg_chain_loader.sv
`timescale 1ns/1ps
module tb_cfg_chain_loader;
   localparam int WORD_W    = 32;
   localparam int LONG_LEN  = 256;
   localparam int SHORT_LEN = 40;
   localparam int MAX_WORDS = 16;
`ifdef CFG_CHAIN_LOADER_CRC_EN
   localparam int TAIL_CYC = 1;
`else
   localparam int TAIL_CYC = 0;
`endif

   typedef struct {
      bit          use_short;
      logic [31:0] first_word;
      logic [31:0] other_word;
      int          stall_word;
      int          stall_len;
      int          start_at;
      int          exp_edges;
      bit          exp_error;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, start_s = 1'b0, abort = 1'b0, word_valid = 1'b0, config_data_in = 1'b0;
   logic [WORD_W-1:0] word_data = '0;
   logic word_ready, config_en, config_data_out, busy, done, error;
   logic word_ready_s, config_en_s, config_data_out_s, busy_s, done_s, error_s;
   bit   sel_short = 1'b0;
   logic m_ready, m_en, m_dout, m_busy, m_done, m_error;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] words [MAX_WORDS];
   bit          exp_q[$];
   bit          got_q[$];
   int          overlap_cnt;
   logic [15:0] crc_xor = 16'h0000;

   always #5 clk = ~clk;

   cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LONG_LEN)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .config_en(config_en), .config_data_out(config_data_out),
      .config_data_in(config_data_in), .busy(busy), .done(done), .error(error));

   cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(SHORT_LEN)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .abort(abort),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready_s),
      .config_en(config_en_s), .config_data_out(config_data_out_s),
      .config_data_in(config_data_in), .busy(busy_s), .done(done_s), .error(error_s));

   assign m_ready = sel_short ? word_ready_s      : word_ready;
   assign m_en    = sel_short ? config_en_s       : config_en;
   assign m_dout  = sel_short ? config_data_out_s : config_data_out;
   assign m_busy  = sel_short ? busy_s            : busy;
   assign m_done  = sel_short ? done_s            : done;
   assign m_error = sel_short ? error_s           : error;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

`ifdef CFG_CHAIN_LOADER_CRC_EN
   // CRC-16-CCITT over the expected stream, bit by bit in shift order.
   function automatic logic [15:0] crc_of_stream();
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (exp_q[i]) begin
         fb = c[15] ^ exp_q[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction
`endif

   // Expected serial stream: each word contributes its low min(32, left)
   // bits, highest first, until len bits have been produced.
   task automatic build_model(input int len);
      int left, n, w;
      exp_q.delete();
      left = len;
      w    = 0;
      while (left > 0) begin
         n = (left < WORD_W) ? left : WORD_W;
         for (int b = n - 1; b >= 0; b--) exp_q.push_back(words[w][b]);
         left -= n;
         w++;
      end
`ifdef CFG_CHAIN_LOADER_CRC_EN
      words[w] = {16'h0000, crc_of_stream() ^ crc_xor};
`endif
   endtask

   task automatic check_stream(input string tag);
      int first_bad;
      first_bad = -1;
      check({tag, " en_cycles"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i] && first_bad < 0) first_bad = i;
      check({tag, " first_bad_bit"}, first_bad, -1);
      check({tag, " ready_with_en"}, overlap_cnt, 0);
   endtask

   // Runs one load from a negedge. Returns the number of clock edges from the
   // start edge up to and including the edge that raised done (-1 if none).
   task automatic run_load(input int len, input int stall_word, input int stall_len,
                           input bit rand_valid, input int abort_at, input int start_at,
                           output int edges);
      int idx, stall_cnt, shift_cnt;
      bit accept, abort_sent, start_sent;
      idx = 0; stall_cnt = 0; shift_cnt = 0;
      abort_sent = 0; start_sent = 0;
      got_q.delete();
      overlap_cnt = 0;
      edges = -1;
      build_model(len);
      if (sel_short) start_s = 1'b1; else start = 1'b1;
      for (int e = 1; e <= 2000; e++) begin
         accept = m_ready && word_valid;
         @(posedge clk);
         if (accept) idx++;
         @(negedge clk);
         start = 1'b0; start_s = 1'b0; abort = 1'b0;
         if (abort_sent) break;
         if (m_en) begin
            got_q.push_back(m_dout);
            shift_cnt++;
         end
         if (m_en && m_ready) overlap_cnt++;
         if (m_done) begin
            edges = e;
            break;
         end
         if (abort_at >= 0 && !abort_sent && shift_cnt == abort_at) begin
            abort = 1'b1;
            abort_sent = 1;
         end
         if (start_at >= 0 && !start_sent && shift_cnt == start_at) begin
            if (sel_short) start_s = 1'b1; else start = 1'b1;
            start_sent = 1;
         end
         word_data      = words[(idx < MAX_WORDS) ? idx : MAX_WORDS - 1];
         config_data_in = 1'($urandom);
         if (m_ready && idx == stall_word && stall_cnt < stall_len) begin
            word_valid = 1'b0;
            stall_cnt++;
         end else if (rand_valid) begin
            word_valid = ($urandom_range(0, 2) != 0);
         end else begin
            word_valid = 1'b1;
         end
      end
      word_valid = 1'b0;
      $display("load len=%0d words=%0d en_bits=%0d edges=%0d done=%0b error=%0b",
               len, idx, got_q.size(), edges, m_done, m_error);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      int   edges;
      int   len;

      vecs[0] = '{0, 32'hA5A5A5A5, 32'hA5A5A5A5, -1, 0, -1, 265, 0};
      vecs[1] = '{1, 32'hFFFFFFFF, 32'h5A5A5AA5, -1, 0, -1, 43, 0};
      vecs[2] = '{0, 32'hA5A5A5A5, 32'hA5A5A5A5,  2, 5, -1, 270, 0};
      vecs[3] = '{0, 32'hA5A5A5A5, 32'hA5A5A5A5, -1, 0, 50, 265, 1};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset outputs long", {word_ready, config_en, config_data_out, busy, done, error}, 0);
      check("reset outputs short", {word_ready_s, config_en_s, config_data_out_s, busy_s, done_s, error_s}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Vector table
      for (int v = 0; v < 4; v++) begin
         sel_short = vecs[v].use_short;
         len = sel_short ? SHORT_LEN : LONG_LEN;
         words[0] = vecs[v].first_word;
         for (int i = 1; i < MAX_WORDS; i++) words[i] = vecs[v].other_word;
         run_load(len, vecs[v].stall_word, vecs[v].stall_len, 0, -1, vecs[v].start_at, edges);
         check($sformatf("v%0d done_edges", v), edges, vecs[v].exp_edges + TAIL_CYC);
         check($sformatf("v%0d error", v), m_error, vecs[v].exp_error);
         check_stream($sformatf("v%0d", v));
      end

      // error stays set in DONE, then clears on the next start
      sel_short = 0;
      repeat (3) @(negedge clk);
      check("sticky error in done", {done, error}, 2'b11);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start clears error", {error, done, word_ready, config_en, busy}, 5'b00101);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort from load", {busy, done, word_ready, config_en}, 4'b0000);

      // Abort at shift cycle 100, then a full load
      for (int i = 0; i < MAX_WORDS; i++) words[i] = 32'hA5A5A5A5;
      run_load(LONG_LEN, -1, 0, 0, 100, -1, edges);
      check("abort en_bits_before", got_q.size(), 100);
      check("abort next cycle", {config_en, word_ready, busy, done}, 4'b0000);
      check("abort no done edge", edges, -1);
      run_load(LONG_LEN, -1, 0, 0, -1, -1, edges);
      check("after abort edges", edges, 265 + TAIL_CYC);
      check("after abort error", error, 0);
      check_stream("after abort");

      // abort and start together in DONE: abort wins
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort beats start", {busy, done, word_ready, config_en}, 4'b0000);

      // Asynchronous reset mid-shift
      start = 1'b1;
      word_valid = 1'b1;
      word_data = 32'hFFFFFFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("pre-reset shifting", {config_en, config_data_out, busy}, 3'b111);
      #1 rst = 1'b1;
      #1;
      check("async reset outputs", {word_ready, config_en, config_data_out, busy, done, error}, 0);
      word_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Randomized loads against the stream model
      for (int r = 0; r < 6; r++) begin
         sel_short = (r % 2) == 1;
         len = sel_short ? SHORT_LEN : LONG_LEN;
         for (int i = 0; i < MAX_WORDS; i++) words[i] = $urandom;
         run_load(len, -1, 0, 1, -1, -1, edges);
         check($sformatf("rand%0d done", r), m_done, 1);
         check($sformatf("rand%0d error", r), m_error, 0);
         check_stream($sformatf("rand%0d", r));
      end

`ifdef CFG_CHAIN_LOADER_CRC_EN
      // All-zero stream with good and corrupted CRC word
      sel_short = 0;
      for (int i = 0; i < MAX_WORDS; i++) words[i] = 32'h0;
      crc_xor = 16'h0000;
      run_load(LONG_LEN, -1, 0, 0, -1, -1, edges);
      check("crc good error", error, 0);
      check("crc good done", done, 1);
      check_stream("crc good");
      for (int i = 0; i < MAX_WORDS; i++) words[i] = 32'h0;
      crc_xor = 16'h0001;
      run_load(LONG_LEN, -1, 0, 0, -1, -1, edges);
      check("crc bad error", error, 1);
      check("crc bad done", done, 1);
      crc_xor = 16'h0000;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
